// File: rtl/sipo_shiftreg_if.sv
// sipo_shiftreg_if
// Bundles the control, handshake and status signals of the serial-to-parallel
// receive shifter. The clock and reset are not part of this bundle.
//
// Signals:
//   clear_in     flush the partial word and the overrun flag
//   shift_in     sample bit_in on this clock edge
//   bit_in       serial data bit
//   ack_in       consumer accepts data_out
//   data_out     last completed word
//   valid_out    data_out holds a word that has not been acknowledged
//   busy_out     a partial word is in progress
//   overrun_out  sticky: a word was dropped because the holding register was full
//
// Modports:
//   master  the side that feeds bits and consumes words
//   slave   the receive shifter itself
interface sipo_shiftreg_if #(
   parameter int WIDTH = 8
);
   logic             clear_in;
   logic             shift_in;
   logic             bit_in;
   logic             ack_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             busy_out;
   logic             overrun_out;

   modport master (
      output clear_in, shift_in, bit_in, ack_in,
      input  data_out, valid_out, busy_out, overrun_out
   );

   modport slave (
      input  clear_in, shift_in, bit_in, ack_in,
      output data_out, valid_out, busy_out, overrun_out
   );
endinterface

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg
// One-word holding register that sits behind the receive shifter. It presents
// each completed word to the consumer with a valid/ack handshake and flags an
// overrun when a new word arrives while the previous one is still unread.
//
// Ports:
//   clock_in     system clock, rising edge
//   n_reset_in   asynchronous reset, active low
//   clear_in     clears the overrun flag (held word and valid are kept)
//   ack_in       consumer accepts data_out; ignored while valid_out is low
//   word_done    a complete word is available on word this cycle
//   word         the completed word
//   data_out     held word, stable while valid_out is high
//   valid_out    data_out holds an unacknowledged word
//   overrun_out  sticky overrun flag
module sipo_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock_in,
   input  logic             n_reset_in,
   input  logic             clear_in,
   input  logic             ack_in,
   input  logic             word_done,
   input  logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             overrun_out
);

   // The slot counts as free when empty, or when the consumer empties it on
   // this very edge, so a back-to-back word with an ack never overruns.
   logic hold_free;

   assign hold_free = !valid_out || ack_in;

   // Load a new word only into a free slot; otherwise drop it and remember the
   // loss. clear_in is applied last so it wins over a simultaneous overrun.
   always_ff @(posedge clock_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         data_out    <= '0;
         valid_out   <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         if (word_done) begin
            if (hold_free) begin
               data_out  <= word;
               valid_out <= 1'b1;
            end else begin
               overrun_out <= 1'b1;
            end
         end else if (valid_out && ack_in) begin
            valid_out <= 1'b0;
         end
         if (clear_in) begin
            overrun_out <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sipo_shiftreg.sv
// sipo_shiftreg
// Serial-to-parallel receive shift register. Assembles WIDTH bits strobed in by
// shift_in and hands each completed word to a one-word holding register with a
// valid/ack handshake and a sticky overrun flag.
//
// Parameters:
//   WIDTH  word width in bits (>= 2)
//   LEFT   0: LSB first, bits enter at the MSB and shift right
//          1: MSB first, bits enter at the LSB and shift left
//
// Ports:
//   clock_in    system clock, rising edge
//   n_reset_in  asynchronous reset, active low
//   bus         sipo_shiftreg_if slave modport (control, handshake, status)
module sipo_shiftreg #(
   parameter int WIDTH = 8,
   parameter bit LEFT  = 1'b0
) (
   input  logic              clock_in,
   input  logic              n_reset_in,
   sipo_shiftreg_if.slave    bus
);

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   localparam int              CNT_W      = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [CNT_W-1:0] bit_count;
   logic             word_done;

   // The shifted value is formed once and used both as the register update and
   // as the completed word, so the word includes the bit sampled on this edge.
   always_comb begin
      shift_next = shift_reg;
      if (LEFT) begin
         shift_next = {shift_reg[WIDTH-2:0], bus.bit_in};
      end else begin
         shift_next = {bus.bit_in, shift_reg[WIDTH-1:1]};
      end
   end

   assign word_done = bus.shift_in && !bus.clear_in && (bit_count == LAST_COUNT);

   // Shift/count datapath. clear_in beats shift_in, and the count wraps to 0
   // on the completing edge so the next word starts without a gap cycle.
   always_ff @(posedge clock_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         shift_reg <= '0;
         bit_count <= '0;
      end else if (bus.clear_in) begin
         shift_reg <= '0;
         bit_count <= '0;
      end else if (bus.shift_in) begin
         shift_reg <= shift_next;
         if (word_done) begin
            bit_count <= '0;
         end else begin
            bit_count <= bit_count + CNT_W'(1);
         end
      end
   end

   assign bus.busy_out = (bit_count != '0);

   sipo_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clock_in    (clock_in),
      .n_reset_in  (n_reset_in),
      .clear_in    (bus.clear_in),
      .ack_in      (bus.ack_in),
      .word_done   (word_done),
      .word        (shift_next),
      .data_out    (bus.data_out),
      .valid_out   (bus.valid_out),
      .overrun_out (bus.overrun_out)
   );

endmodule

// File: tb/tb_sipo_shiftreg.sv
// tb_sipo_shiftreg
// Drives an LSB-first (LEFT=0) and an MSB-first (LEFT=1) receive shifter with
// the same bit stream and compares both against a behavioural model that keeps
// the received bits in an array and builds words arithmetically.
module tb_sipo_shiftreg;

   logic clock_in = 1'b0;
   logic n_reset_in;
   logic clear, shift, bitv, ack;

   int checks = 0;
   int errors = 0;

   sipo_shiftreg_if #(.WIDTH(8)) busL ();
   sipo_shiftreg_if #(.WIDTH(8)) busM ();

   assign busL.clear_in = clear;
   assign busL.shift_in = shift;
   assign busL.bit_in   = bitv;
   assign busL.ack_in   = ack;
   assign busM.clear_in = clear;
   assign busM.shift_in = shift;
   assign busM.bit_in   = bitv;
   assign busM.ack_in   = ack;

   sipo_shiftreg #(.WIDTH(8), .LEFT(1'b0)) dutL (
      .clock_in   (clock_in),
      .n_reset_in (n_reset_in),
      .bus        (busL)
   );

   sipo_shiftreg #(.WIDTH(8), .LEFT(1'b1)) dutM (
      .clock_in   (clock_in),
      .n_reset_in (n_reset_in),
      .bus        (busM)
   );

   always #5 clock_in = ~clock_in;

   // Reference model, index 0 = LSB-first device, 1 = MSB-first device.
   int         mBit [2][8];
   int         mCnt [2];
   logic [7:0] mData[2];
   logic       mValid[2];
   logic       mOvr [2];

   function automatic logic [7:0] wordOf(input int d);
      int w;
      w = 0;
      for (int k = 0; k < 8; k++) begin
         if (d == 1) w = w + (mBit[d][k] << (7 - k));
         else        w = w + (mBit[d][k] << k);
      end
      return 8'(w);
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         mCnt[d]   = 0;
         mData[d]  = 8'h00;
         mValid[d] = 1'b0;
         mOvr[d]   = 1'b0;
      end
   endtask

   task automatic modelStep(input logic c, input logic s, input logic b, input logic a);
      logic       done;
      logic [7:0] w;
      for (int d = 0; d < 2; d++) begin
         done = 1'b0;
         w    = 8'h00;
         if (c) begin
            mCnt[d] = 0;
            mOvr[d] = 1'b0;
         end else if (s) begin
            mBit[d][mCnt[d]] = int'(b);
            mCnt[d]++;
            if (mCnt[d] == 8) begin
               done    = 1'b1;
               w       = wordOf(d);
               mCnt[d] = 0;
            end
         end
         if (done) begin
            if (!mValid[d] || a) begin
               mData[d]  = w;
               mValid[d] = 1'b1;
            end else begin
               mOvr[d] = 1'b1;
            end
         end else if (mValid[d] && a) begin
            mValid[d] = 1'b0;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic checkAll(input string phase);
      checkOutput({phase, " L data"},    32'(busL.data_out),    32'(mData[0]));
      checkOutput({phase, " L valid"},   32'(busL.valid_out),   32'(mValid[0]));
      checkOutput({phase, " L busy"},    32'(busL.busy_out),    32'(mCnt[0] != 0));
      checkOutput({phase, " L overrun"}, 32'(busL.overrun_out), 32'(mOvr[0]));
      checkOutput({phase, " M data"},    32'(busM.data_out),    32'(mData[1]));
      checkOutput({phase, " M valid"},   32'(busM.valid_out),   32'(mValid[1]));
      checkOutput({phase, " M busy"},    32'(busM.busy_out),    32'(mCnt[1] != 0));
      checkOutput({phase, " M overrun"}, 32'(busM.overrun_out), 32'(mOvr[1]));
   endtask

   task automatic applyStimulus(input string phase, input logic c, input logic s,
                                input logic b, input logic a);
      clear = c;
      shift = s;
      bitv  = b;
      ack   = a;
      @(posedge clock_in);
      modelStep(c, s, b, a);
      #1;
      checkAll(phase);
      clear = 1'b0;
      shift = 1'b0;
      bitv  = 1'b0;
      ack   = 1'b0;
   endtask

   // Asserts reset between edges and checks the outputs clear without a clock.
   task automatic resetDut(input string phase);
      clear      = 1'b0;
      shift      = 1'b0;
      bitv       = 1'b0;
      ack        = 1'b0;
      n_reset_in = 1'b0;
      #2;
      modelReset();
      checkAll(phase);
      n_reset_in = 1'b1;
      #1;
   endtask

   task automatic sendWord(input string phase, input logic [7:0] w,
                           input bit msbFirst, input bit ackLast);
      logic [7:0] v;
      v = w;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(phase, 1'b0, 1'b1, msbFirst ? v[7-k] : v[k], ackLast && (k == 7));
      end
   endtask

   initial begin
      logic [7:0] pattern;
      clear      = 1'b0;
      shift      = 1'b0;
      bitv       = 1'b0;
      ack        = 1'b0;
      n_reset_in = 1'b0;
      modelReset();
      #2;
      checkAll("reset");
      @(negedge clock_in);
      n_reset_in = 1'b1;
      @(posedge clock_in);
      #1;

      // Test 1: LSB first A5, busy during bits 2..8.
      pattern = 8'b1010_0101;
      for (int k = 0; k < 8; k++) begin
         applyStimulus("t1", 1'b0, 1'b1, pattern[k], 1'b0);
         if (k < 7) checkOutput("t1 busy", 32'(busL.busy_out), 32'd1);
      end
      checkOutput("t1 data",  32'(busL.data_out),  32'h0A5);
      checkOutput("t1 valid", 32'(busL.valid_out), 32'd1);
      checkOutput("t1 busy after", 32'(busL.busy_out), 32'd0);
      applyStimulus("t1 ack", 1'b0, 1'b0, 1'b0, 1'b1);

      // Test 2: MSB first 3C with three idle cycles between bits.
      pattern = 8'h3C;
      for (int k = 0; k < 8; k++) begin
         applyStimulus("t2", 1'b0, 1'b1, pattern[7-k], 1'b0);
         for (int g = 0; g < 3; g++) applyStimulus("t2 idle", 1'b0, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("t2 data",  32'(busM.data_out),  32'h03C);
      checkOutput("t2 valid", 32'(busM.valid_out), 32'd1);

      // Test 3: overrun, then ack, then clear.
      resetDut("t3 reset");
      sendWord("t3 w1", 8'h11, 1'b0, 1'b0);
      sendWord("t3 w2", 8'h22, 1'b0, 1'b0);
      checkOutput("t3 data held", 32'(busL.data_out),    32'h011);
      checkOutput("t3 overrun",   32'(busL.overrun_out), 32'd1);
      applyStimulus("t3 ack", 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("t3 valid after ack", 32'(busL.valid_out),   32'd0);
      checkOutput("t3 ovr after ack",   32'(busL.overrun_out), 32'd1);
      applyStimulus("t3 clear", 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t3 ovr after clear", 32'(busL.overrun_out), 32'd0);

      // Test 4: ack on the completing edge of the second word.
      resetDut("t4 reset");
      sendWord("t4 w1", 8'h11, 1'b0, 1'b0);
      sendWord("t4 w2", 8'h22, 1'b0, 1'b1);
      checkOutput("t4 data",    32'(busL.data_out),    32'h022);
      checkOutput("t4 valid",   32'(busL.valid_out),   32'd1);
      checkOutput("t4 overrun", 32'(busL.overrun_out), 32'd0);

      // Test 5: clear together with shift drops that bit.
      resetDut("t5 reset");
      for (int k = 0; k < 3; k++) applyStimulus("t5 part", 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus("t5 clear", 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("t5 busy after clear", 32'(busL.busy_out), 32'd0);
      sendWord("t5 word", 8'h5A, 1'b0, 1'b0);
      checkOutput("t5 data", 32'(busL.data_out), 32'h05A);

      // Test 6: asynchronous reset mid-word, then exactly 8 shifts of FF.
      for (int k = 0; k < 5; k++) applyStimulus("t6 part", 1'b0, 1'b1, 1'b1, 1'b1);
      resetDut("t6 async reset");
      for (int k = 0; k < 8; k++) begin
         applyStimulus("t6 word", 1'b0, 1'b1, 1'b1, 1'b0);
         if (k == 6) checkOutput("t6 valid after 7", 32'(busL.valid_out), 32'd0);
      end
      checkOutput("t6 data",  32'(busL.data_out),  32'h0FF);
      checkOutput("t6 valid", 32'(busL.valid_out), 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            resetDut("rand reset");
         end else begin
            applyStimulus("rand",
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) != 0,
                          1'($urandom),
                          $urandom_range(0, 4) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
